// File: rtl/eq_bar_display.sv
// 16-band equaliser bar renderer for an XVGA timing stream.
// A shadow bank takes level writes at any time. Once per frame, at the first
// vblank line, the shadow bank is copied into the active bank and the peak
// markers are updated, one band per cycle. The two-stage pixel pipeline reads
// only the active and peak banks, so a frame never tears on mid-frame writes.
module eq_bar_display #(
  parameter int          HOLD_FRAMES = 30,
  parameter int          DECAY       = 1,
  parameter logic [23:0] BAR_COLOR   = 24'h00FF00,
  parameter logic [23:0] PEAK_COLOR  = 24'hFF0000
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic        lvl_we,
  input  logic [3:0]  lvl_addr,
  input  logic [7:0]  lvl_data,
  output logic [23:0] pixel,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        commit_busy
);

  localparam int          HW      = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [8:0]  DECAY_W = 9'(DECAY);

  typedef enum logic [0:0] {IDLE, COMMIT} state_t;

  state_t        state, state_next;
  logic [3:0]    idx, idx_next;
  logic [7:0]    shadow [0:15];
  logic [7:0]    active [0:15];
  logic [7:0]    peak   [0:15];
  logic [HW-1:0] hold   [0:15];
  logic          frame_tick;

  logic [7:0]    cur_lvl, cur_pk, new_pk;
  logic [HW-1:0] cur_hold, new_hold;
  logic [8:0]    decayed;

  logic          s1_col_ok, s1_hs, s1_vs, s1_blank;
  logic [9:0]    s1_vcount;
  logic [7:0]    s1_lvl, s1_pk;
  logic [9:0]    bar_top, pk_line;
  logic          bar_on, pk_on;
  logic [23:0]   pixel_next;

  // First line of vertical blanking starts the copy walk.
  assign frame_tick  = (hcount == 11'd0) && (vcount == 10'd768);
  assign commit_busy = (state == COMMIT);

  // FSM state and walk index register.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state logic: a tick while walking is ignored, the walk always ends at 15.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          state_next = COMMIT;
          idx_next   = 4'd0;
        end else begin
          state_next = IDLE;
        end
      end
      COMMIT: begin
        if (idx == 4'd15) begin
          state_next = IDLE;
          idx_next   = 4'd0;
        end else begin
          idx_next   = idx + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 4'd0;
      end
    endcase
  end

  // Shadow bank accepts writes at any time, including during the walk.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) shadow[k] <= 8'd0;
    end else if (lvl_we) begin
      shadow[lvl_addr] <= lvl_data;
    end
  end

  assign cur_lvl  = shadow[idx];
  assign cur_pk   = peak[idx];
  assign cur_hold = hold[idx];
  assign decayed  = {1'b0, cur_pk} - DECAY_W;

  // Peak rule: capture and re-arm hold on a new high, else count hold down, else decay toward the level.
  always_comb begin
    new_pk   = cur_pk;
    new_hold = cur_hold;
    if (cur_lvl >= cur_pk) begin
      new_pk   = cur_lvl;
      new_hold = HW'(HOLD_FRAMES);
    end else if (cur_hold != '0) begin
      new_hold = cur_hold - HW'(1);
    end else if (({1'b0, cur_pk} < DECAY_W) || (decayed < {1'b0, cur_lvl})) begin
      new_pk   = cur_lvl;
    end else begin
      new_pk   = decayed[7:0];
    end
  end

  // Active/peak/hold banks are written only by the walk, one band per cycle.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        active[k] <= 8'd0;
        peak[k]   <= 8'd0;
        hold[k]   <= '0;
      end
    end else if (state == COMMIT) begin
      active[idx] <= cur_lvl;
      peak[idx]   <= new_pk;
      hold[idx]   <= new_hold;
    end
  end

  // Stage 1: band decode and bank read; columns past 1023 are always blanking in XVGA.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      s1_col_ok <= 1'b0;
      s1_vcount <= 10'd0;
      s1_lvl    <= 8'd0;
      s1_pk     <= 8'd0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_blank  <= 1'b1;
    end else begin
      s1_col_ok <= !hcount[10] && (hcount[5:0] < 6'd56);
      s1_vcount <= vcount;
      s1_lvl    <= active[hcount[9:6]];
      s1_pk     <= peak[hcount[9:6]];
      s1_hs     <= hsync;
      s1_vs     <= vsync;
      s1_blank  <= blank;
    end
  end

  assign bar_top = 10'd640 - {1'b0, s1_lvl, 1'b0};
  assign pk_line = 10'd639 - {1'b0, s1_pk, 1'b0};
  assign bar_on  = s1_col_ok && (s1_lvl != 8'd0) && (s1_vcount >= bar_top) && (s1_vcount <= 10'd639);
  assign pk_on   = s1_col_ok && (s1_pk != 8'd0) &&
                   ((s1_vcount == pk_line) || (s1_vcount == pk_line - 10'd1));

  // Colour priority: blanking, then peak marker, then bar, then background.
  always_comb begin
    pixel_next = 24'h000000;
    if (s1_blank) begin
      pixel_next = 24'h000000;
    end else if (pk_on) begin
      pixel_next = PEAK_COLOR;
    end else if (bar_on) begin
      pixel_next = BAR_COLOR;
    end else begin
      pixel_next = 24'h000000;
    end
  end

  // Stage 2: registered pixel and timing outputs.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      pixel     <= 24'h000000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      pixel     <= pixel_next;
      hsync_out <= s1_hs;
      vsync_out <= s1_vs;
      blank_out <= s1_blank;
    end
  end

endmodule

// File: tb/tb_eq_bar_display.sv
// Scoreboard bench for eq_bar_display: a driver pushes expected outputs,
// a monitor pops and compares them when they come due.
module tb_eq_bar_display;

  localparam int HOLD  = 30;
  localparam int DEC   = 1;

  logic        vclock = 1'b0;
  logic        reset  = 1'b1;
  logic [10:0] hcount = 11'd0;
  logic [9:0]  vcount = 10'd0;
  logic        hsync = 1'b1, vsync = 1'b1, blank = 1'b1;
  logic        lvl_we = 1'b0;
  logic [3:0]  lvl_addr = 4'd0;
  logic [7:0]  lvl_data = 8'd0;
  logic [23:0] pixel;
  logic        hsync_out, vsync_out, blank_out, commit_busy;

  eq_bar_display dut (
    .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .lvl_we(lvl_we), .lvl_addr(lvl_addr), .lvl_data(lvl_data),
    .pixel(pixel), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .blank_out(blank_out), .commit_busy(commit_busy)
  );

  always #5 vclock = ~vclock;

  typedef struct {
    logic [23:0] pix;
    logic        hs;
    logic        vs;
    logic        bl;
    int          due;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state: plain integers per band.
  int shadow [16];
  int active [16];
  int peak   [16];
  int hold   [16];
  int cidx = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [23:0] ref_pixel(input int hc, input int vc, input bit bl);
    int b, col, p, a;
    b   = (hc / 64) % 16;
    col = hc % 64;
    if (bl) return 24'h000000;
    if (col < 56) begin
      p = peak[b];
      if (p != 0 && (vc == 638 - 2 * p || vc == 639 - 2 * p)) return 24'hFF0000;
      a = active[b];
      if (a != 0 && vc >= 640 - 2 * a && vc <= 639) return 24'h00FF00;
    end
    return 24'h000000;
  endfunction

  task automatic model_commit(input int i);
    int l;
    l = shadow[i];
    active[i] = l;
    if (l >= peak[i]) begin
      peak[i] = l;
      hold[i] = HOLD;
    end else if (hold[i] != 0) begin
      hold[i] = hold[i] - 1;
    end else begin
      peak[i] = (peak[i] - DEC > l) ? peak[i] - DEC : l;
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 16; k++) begin
      shadow[k] = 0; active[k] = 0; peak[k] = 0; hold[k] = 0;
    end
    cidx = -1;
  endtask

  // One pixel-clock of stimulus; the expected response is queued for the monitor.
  task automatic drive(input int hc, input int vc, input bit bl, input bit we, input int addr, input int data);
    exp_t e;
    bit   was_idle;
    @(negedge vclock);
    check("commit_busy", {31'd0, commit_busy}, {31'd0, (cidx >= 0)});
    hcount   = 11'(hc);
    vcount   = 10'(vc);
    blank    = bl;
    hsync    = 1'($urandom);
    vsync    = 1'($urandom);
    lvl_we   = we;
    lvl_addr = 4'(addr);
    lvl_data = 8'(data);
    e.pix = ref_pixel(hc, vc, bl);
    e.hs  = hsync;
    e.vs  = vsync;
    e.bl  = bl;
    e.due = cyc + 2;
    q.push_back(e);
    was_idle = (cidx < 0);
    if (!was_idle) begin
      model_commit(cidx);
      cidx++;
      if (cidx == 16) cidx = -1;
    end
    if (we) shadow[addr] = data;
    if (was_idle && hc == 0 && vc == 768) cidx = 0;
  endtask

  task automatic do_reset();
    @(negedge vclock);
    reset  = 1'b1;
    lvl_we = 1'b0;
    q.delete();
    model_clear();
    #1;
    check("rst_pixel", {8'd0, pixel}, 32'd0);
    check("rst_hsync", {31'd0, hsync_out}, 32'd1);
    check("rst_vsync", {31'd0, vsync_out}, 32'd1);
    check("rst_blank", {31'd0, blank_out}, 32'd1);
    check("rst_busy",  {31'd0, commit_busy}, 32'd0);
    repeat (3) @(negedge vclock);
    reset = 1'b0;
  endtask

  // Frame tick plus the 16-cycle walk, in blanking. Optional same-cycle write,
  // a second tick mid-walk, and a reset at a chosen walk index.
  task automatic do_commit(input int wr_idx, input int wr_data, input bit dbl_tick, input int rst_at);
    drive(0, 768, 1'b1, 1'b0, 0, 0);
    for (int j = 0; j < 16; j++) begin
      if (j == rst_at) begin
        do_reset();
        return;
      end
      if (dbl_tick && j == 5)
        drive(0, 768, 1'b1, (j == wr_idx), j, wr_data);
      else
        drive($urandom_range(1, 1023), 769 + j, 1'b1, (j == wr_idx), j, wr_data);
    end
    drive($urandom_range(1, 1023), 790, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic sample_band(input int b, input int vc, input bit bl);
    drive(b * 64 + $urandom_range(0, 63), vc, bl, 1'b0, 0, 0);
  endtask

  task automatic random_frame(input int n);
    for (int k = 0; k < n; k++) begin
      bit we;
      we = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 1023), $urandom_range(120, 650), ($urandom_range(0, 7) == 0),
            we, $urandom_range(0, 15), $urandom_range(0, 255));
    end
  endtask

  // Monitor: compares each queued expectation on the cycle it comes due.
  initial begin
    exp_t e;
    forever begin
      @(posedge vclock);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check("pixel",     {8'd0, pixel},      {8'd0, e.pix});
        check("hsync_out", {31'd0, hsync_out}, {31'd0, e.hs});
        check("vsync_out", {31'd0, vsync_out}, {31'd0, e.vs});
        check("blank_out", {31'd0, blank_out}, {31'd0, e.bl});
      end
    end
  end

  initial begin
    model_clear();
    do_reset();

    // Band 3 at 100: bar lines 440..639, marker 438..439, gap columns dark.
    drive(500, 10, 1'b0, 1'b1, 3, 100);
    do_commit(-1, 0, 1'b0, -1);
    foreach (shadow[k]) begin end
    begin
      int lines [8] = '{436, 437, 438, 439, 440, 500, 639, 640};
      for (int li = 0; li < 8; li++)
        for (int hc = 190; hc < 258; hc++)
          drive(hc, lines[li], 1'b0, 1'b0, 0, 0);
    end
    drive(200, 500, 1'b1, 1'b0, 0, 0);

    // Mid-frame write to band 0 does not show until the next walk.
    drive(10, 300, 1'b0, 1'b1, 0, 200);
    for (int v = 238; v < 242; v++) sample_band(0, v, 1'b0);
    do_commit(-1, 0, 1'b0, -1);
    for (int v = 236; v < 242; v++) sample_band(0, v, 1'b0);
    sample_band(0, 639, 1'b0);

    // Same-cycle write at index 7 during the walk, plus an ignored second tick.
    drive(10, 300, 1'b0, 1'b1, 7, 50);
    do_commit(-1, 0, 1'b0, -1);
    do_commit(7, 99, 1'b1, -1);
    for (int v = 436; v < 444; v++) sample_band(7, v, 1'b0);
    for (int v = 536; v < 542; v++) sample_band(7, v, 1'b0);
    do_commit(-1, 0, 1'b0, -1);
    for (int v = 436; v < 444; v++) sample_band(7, v, 1'b0);
    for (int v = 536; v < 542; v++) sample_band(7, v, 1'b0);

    // Band 5: one frame at 255, then 0; peak holds then decays one level per walk.
    drive(10, 300, 1'b0, 1'b1, 5, 255);
    do_commit(-1, 0, 1'b0, -1);
    drive(10, 300, 1'b0, 1'b1, 5, 0);
    for (int f = 0; f < 36; f++) begin
      do_commit(-1, 0, 1'b0, -1);
      for (int v = 126; v < 132; v++) sample_band(5, v, 1'b0);
      sample_band(5, 639, 1'b0);
      drive(5 * 64 + 60, 129, 1'b0, 1'b0, 0, 0);
    end

    // Reset at walk index 8, then a full walk after release.
    drive(10, 300, 1'b0, 1'b1, 9, 77);
    do_commit(-1, 0, 1'b0, 8);
    drive(10, 300, 1'b0, 1'b1, 2, 180);
    do_commit(-1, 0, 1'b0, -1);
    for (int v = 276; v < 284; v++) sample_band(2, v, 1'b0);
    sample_band(9, 600, 1'b0);

    // Randomised frames with writes during drawing and during the walk.
    for (int f = 0; f < 25; f++) begin
      random_frame(60);
      if ($urandom_range(0, 1) == 1)
        do_commit($urandom_range(0, 15), $urandom_range(0, 255), 1'b0, -1);
      else
        do_commit(-1, 0, 1'b0, -1);
    end

    lvl_we = 1'b0;
    repeat (4) @(negedge vclock);
    check("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eq_bar_display.md
EQ_BAR_DISPLAY -- requirements
Module: eq_bar_display

Interface
REQ-001 Parameter HOLD_FRAMES, default 30: frames a peak marker holds before decaying.
REQ-002 Parameter DECAY, default 1: levels the peak drops per frame after hold expires.
REQ-003 Parameter BAR_COLOR, default 24'h00FF00: bar pixel colour.
REQ-004 Parameter PEAK_COLOR, default 24'hFF0000: peak marker colour.
REQ-005 vclock  in  1  pixel clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 hcount  in  11  pixel number on current line, from the XVGA timing stage.
REQ-008 vcount  in  10  line number, from the XVGA timing stage.
REQ-009 hsync, vsync, blank  in  1 each  timing-stage syncs (active low) and blank (active high).
REQ-010 lvl_we  in  1  band-level write strobe.
REQ-011 lvl_addr  in  4  band index 0..15.
REQ-012 lvl_data  in  8  band level 0..255.
REQ-013 pixel  out  24  RGB {R[7:0],G[7:0],B[7:0]}.
REQ-014 hsync_out, vsync_out, blank_out  out  1 each  syncs/blank delayed to align with pixel.
REQ-015 commit_busy  out  1  high while the shadow-to-active copy runs.

Function
REQ-016 Shadow bank: 16x8 registers; lvl_we writes lvl_data to shadow[lvl_addr] on the next edge, at any time, including during commit.
REQ-017 frame_tick asserts for one cycle when hcount==0 and vcount==768 (first vblank line).
REQ-018 FSM states IDLE, COMMIT; IDLE->COMMIT on frame_tick; COMMIT processes index i=0..15, one per cycle; COMMIT->IDLE after i==15; commit_busy high exactly in COMMIT (16 cycles).
REQ-019 In COMMIT at index i: active[i] <= shadow[i] as held before that edge; a same-cycle lvl_we to index i updates shadow only and is committed next frame.
REQ-020 Peak update at index i with new level L: if L>=peak[i], peak[i]<=L, hold[i]<=HOLD_FRAMES; else if hold[i]!=0, hold[i]<=hold[i]-1; else peak[i]<=max(peak[i]-DECAY, L), saturating, never below L, no wrap.
REQ-021 frame_tick during COMMIT is ignored (cannot occur with 806-line timing; must not restart the walk).
REQ-022 Geometry: band b = hcount[9:6]; bar columns are hcount[5:0] in 0..55; columns 56..63 are gaps.
REQ-023 Bar lit when vcount in [640-2*active[b], 639]; level 0 draws nothing; 10-bit unsigned arithmetic, top line is 130 at level 255.
REQ-024 Peak marker lit when peak[b]!=0 and vcount in {638-2*peak[b], 639-2*peak[b]} within bar columns; marker overrides bar.
REQ-025 Pixel priority: blank -> 24'h000000; else peak -> PEAK_COLOR; else bar -> BAR_COLOR; else 24'h000000.
REQ-026 Latency: pixel, hsync_out, vsync_out, blank_out reflect inputs sampled exactly 2 cycles earlier (stage 1: band decode and register read; stage 2: compare and colour select).
REQ-027 Drawing uses only active/peak, so a frame never tears on mid-frame writes.

Reset
REQ-028 On reset assertion, asynchronously: pixel=0, hsync_out=1, vsync_out=1, blank_out=1, commit_busy=0, FSM=IDLE, shadow/active/peak/hold all 0.
REQ-029 Reset asserted mid-COMMIT aborts the walk; after release, the next frame_tick starts a full walk from index 0.
REQ-030 Pipeline registers fill normally after release; outputs are valid from the third edge.

Verification
REQ-031 Write band 3=100, run to frame_tick -> commit_busy high 16 cycles; next frame, hcount 192..247 green on lines 440..639; lines 438..439 red; columns 248..255 black.
REQ-032 Write band 0=200 at vcount 300 mid-frame -> current frame unchanged; after next commit, bar top at line 240.
REQ-033 Band 5: level 255 for one frame, then 0 -> peak stays 255 for 30 commits, then drops by 1 per commit; marker visible, bar absent.
REQ-034 lvl_we to index 7 in the same cycle COMMIT processes index 7 -> active[7] gets the old value; the new value appears after the following commit.
REQ-035 Toggle hsync/vsync/blank at known cycles -> outputs mirror with exactly 2-cycle delay; blank high forces pixel 0 over a lit bar.
REQ-036 Assert reset at COMMIT index 8 -> outputs at reset values immediately; after release, the next frame_tick performs a complete 16-cycle commit.
